// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 2-of-3 vote used to reject single-sample noise around mid-bit
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta;

    // Resetting to 1 keeps a reset line looking idle, so no false start bit
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta   <= 1'b1;
            o_Sync <= 1'b1;
        end else begin
            meta   <= i_Async;
            o_Sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: configurable data width, parity and stop bits,
// 3-sample majority decisions, parity/framing/break reporting.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break
);

    localparam int M  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_S0  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1  = CW'(M);
    localparam logic [CW-1:0] CNT_DEC = CW'(M + 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] bit_idx, bit_idx_n;
    logic          stop_idx, stop_idx_n;

    logic                 rx_s;
    logic                 s0, s1;
    logic                 maj, decide, bit_end, finish;
    logic [DATA_BITS-1:0] data_r;
    logic                 par_r, stop_bad, all_zero, arm;
    logic                 par_err, frame_err, brk;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_RX_Serial),
        .o_Sync  (rx_s)
    );

    // Third vote is the live sample, so the decision lands at count M+1
    assign maj     = majority3(s0, s1, rx_s);
    assign decide  = (state != IDLE) && (cnt == CNT_DEC);
    assign bit_end = (cnt == CNT_END);

    // Error flags for the frame closing on this decision
    assign par_err   = (PARITY_MODE != PAR_NONE) &&
                       (((^data_r) ^ par_r) != (PARITY_MODE == PAR_ODD));
    assign frame_err = stop_bad | ~maj;
    assign brk       = frame_err & all_zero & ~maj;

    // State and bit-position registers
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
        end
    end

    // Next-state: bit timing, glitch rejection, frame completion on last stop decision
    always_comb begin
        state_n    = state;
        cnt_n      = bit_end ? '0 : cnt + 1'b1;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n      = '0;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                if (!rx_s && arm) state_n = START;
            end
            START: begin
                if (decide && maj) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_DATA)
                        state_n = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    else
                        bit_idx_n = bit_idx + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // Leave early so a back-to-back start bit is not missed
                if (decide && (stop_idx == LAST_STOP)) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    stop_idx_n = stop_idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Sampling, data capture, error accumulation and output registers
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            data_r       <= '0;
            par_r        <= 1'b0;
            stop_bad     <= 1'b0;
            all_zero     <= 1'b1;
            arm          <= 1'b1;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_RX_DV <= finish;
            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;

            if (state == IDLE) begin
                stop_bad <= 1'b0;
                all_zero <= 1'b1;
                if (rx_s) arm <= 1'b1;
            end

            if (decide) begin
                case (state)
                    DATA: begin
                        data_r[bit_idx] <= maj;
                        all_zero        <= all_zero & ~maj;
                    end
                    PARITY: begin
                        par_r    <= maj;
                        all_zero <= all_zero & ~maj;
                    end
                    STOP: begin
                        if (!maj) stop_bad <= 1'b1;
                        all_zero <= all_zero & ~maj;
                    end
                    default: ;
                endcase
            end

            if (finish) begin
                o_RX_Byte    <= data_r;
                o_Parity_Err <= par_err;
                o_Frame_Err  <= frame_err;
                o_Break      <= brk;
                // A low line after a bad stop must go high before the next start
                if (frame_err) arm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomised bench for uart_rx_framed: three configurations (8N1/87, 8E1/20,
// 7O2/9) driven one at a time; strobes are compared against a frame model.
module tb_uart_rx_framed;

    typedef struct {
        int         d;
        int         stamp;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ser = 3'b111;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    wire [2:0] dv, pe, fe, br;
    wire [7:0] b0, b1;
    wire [6:0] b2;

    frm_t got_q[$];
    frm_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framed #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(ser[0]), .o_RX_DV(dv[0]),
        .o_RX_Byte(b0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(br[0]));

    uart_rx_framed #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(ser[1]), .o_RX_DV(dv[1]),
        .o_RX_Byte(b1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(br[1]));

    uart_rx_framed #(.CLKS_PER_BIT(9), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(ser[2]), .o_RX_DV(dv[2]),
        .o_RX_Byte(b2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(br[2]));

    function automatic int cpb_of(input int d);
        case (d) 0: return 87; 1: return 20; default: return 9; endcase
    endfunction
    function automatic int db_of(input int d);
        return (d == 2) ? 7 : 8;
    endfunction
    function automatic int pm_of(input int d);
        case (d) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int sb_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (dv[0]) got_q.push_back('{d:0, stamp:cyc, data:9'(b0), pe:pe[0], fe:fe[0], brk:br[0]});
        if (dv[1]) got_q.push_back('{d:1, stamp:cyc, data:9'(b1), pe:pe[1], fe:fe[1], brk:br[1]});
        if (dv[2]) got_q.push_back('{d:2, stamp:cyc, data:9'(b2), pe:pe[2], fe:fe[2], brk:br[2]});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame model: line levels per bit period -> what the consumer should see
    function automatic frm_t model(input int d, input logic [31:0] lv, input int e0);
        frm_t f;
        int   db = db_of(d);
        int   pm = pm_of(d);
        int   sb = sb_of(d);
        int   cpb = cpb_of(d);
        int   n = 1 + db + ((pm != 0) ? 1 : 0) + sb;
        int   k;
        f.d = d;
        f.data = '0;
        for (int i = 0; i < db; i++) f.data[i] = lv[1 + i];
        k = 1 + db;
        f.pe = 1'b0;
        if (pm != 0) begin
            f.pe = (((^f.data) ^ lv[k]) != (pm == 2));
            k++;
        end
        f.fe = 1'b0;
        for (int i = 0; i < sb; i++) if (!lv[k + i]) f.fe = 1'b1;
        f.brk = 1'b1;
        for (int i = 1; i < n; i++) if (lv[i]) f.brk = 1'b0;
        f.stamp = e0 + (n - 1) * cpb + (cpb - 1) / 2 + 4;
        return f;
    endfunction

    // par < 0 means send the correct parity bit
    task automatic build(input int d, input logic [8:0] data, input int par,
                         input logic [1:0] stops, output logic [31:0] lv, output int nb);
        int db = db_of(d);
        int pm = pm_of(d);
        int k;
        lv = '1;
        lv[0] = 1'b0;
        for (int i = 0; i < db; i++) lv[1 + i] = data[i];
        k = 1 + db;
        if (pm != 0) begin
            logic x;
            x = 1'b0;
            for (int i = 0; i < db; i++) x = x ^ data[i];
            lv[k] = (par < 0) ? (x ^ (pm == 2)) : par[0];
            k++;
        end
        for (int i = 0; i < sb_of(d); i++) lv[k + i] = stops[i];
        nb = k + sb_of(d);
    endtask

    // Entered and left just after a rising edge, so gap=0 gives back-to-back frames
    task automatic send(input int d, input logic [31:0] lv, input int nb, input int gap);
        int e0;
        int cpb = cpb_of(d);
        e0 = cyc + 1;
        for (int i = 0; i < nb; i++) begin
            ser[d] = lv[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        ser[d] = 1'b1;
        exp_q.push_back(model(d, lv, e0));
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic flush(input string tag, input int settle);
        repeat (settle) @(posedge clk);
        #1;
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s[%0d].dut", tag, i),   got_q[i].d,     exp_q[i].d);
            chk($sformatf("%s[%0d].stamp", tag, i), got_q[i].stamp, exp_q[i].stamp);
            chk($sformatf("%s[%0d].data", tag, i),  got_q[i].data,  exp_q[i].data);
            chk($sformatf("%s[%0d].perr", tag, i),  got_q[i].pe,    exp_q[i].pe);
            chk($sformatf("%s[%0d].ferr", tag, i),  got_q[i].fe,    exp_q[i].fe);
            chk($sformatf("%s[%0d].brk", tag, i),   got_q[i].brk,   exp_q[i].brk);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".dv"},   dv, 3'b000);
        chk({tag, ".pe"},   pe, 3'b000);
        chk({tag, ".fe"},   fe, 3'b000);
        chk({tag, ".brk"},  br, 3'b000);
        chk({tag, ".b0"},   b0, 8'h00);
        chk({tag, ".b1"},   b1, 8'h00);
        chk({tag, ".b2"},   b2, 7'h00);
    endtask

    task automatic rand_frames(input int d, input int cnt);
        logic [31:0] lv;
        logic [8:0]  data;
        logic [1:0]  stops;
        int          nb, par, gap;
        for (int j = 0; j < cnt; j++) begin
            data     = 9'($urandom);
            stops[0] = ($urandom_range(0, 3) != 0);
            stops[1] = ($urandom_range(0, 3) != 0);
            par      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
            build(d, data, par, stops, lv, nb);
            // Bad stop clears the arm flag; the line must idle high before the next start
            gap = (stops[0] && (sb_of(d) == 1 || stops[1])) ?
                  int'($urandom_range(0, cpb_of(d))) : cpb_of(d);
            send(d, lv, nb, gap);
        end
    endtask

    initial begin
        logic [31:0] lv;
        int          nb;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 0xA5: strobe at e0+830
        build(0, 9'h0A5, -1, 2'b11, lv, nb);
        send(0, lv, nb, 20);
        chk("a5.stamp_rule", exp_q[0].stamp - (cyc - 20 - 10 * 87 + 1), 830);
        flush("a5", 3 * 87);
        rand_frames(0, 5);
        flush("rand0", 3 * 87);

        // 8E1: wrong then correct parity on 0x3C
        build(1, 9'h03C, 1, 2'b11, lv, nb);
        send(1, lv, nb, 5);
        build(1, 9'h03C, 0, 2'b11, lv, nb);
        send(1, lv, nb, 5);
        flush("par3c", 60);
        rand_frames(1, 10);
        flush("rand1", 60);

        // 7O2: second stop low, line then held low; one strobe only
        build(2, 9'h055, -1, 2'b01, lv, nb);
        for (int i = nb; i < 32; i++) lv[i] = 1'b0;
        send(2, lv, 32, 20);
        flush("stop2", 30);
        build(2, 9'h02A, -1, 2'b11, lv, nb);
        send(2, lv, nb, 0);
        rand_frames(2, 12);
        flush("rand2", 30);

        // Break: 12 bit periods low
        send(0, 32'h0, 12, 0);
        flush("break", 4 * 87);

        // Short glitch rejected, then 0x81 received
        ser[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        ser[0] = 1'b1;
        flush("glitch", 3 * 87);
        build(0, 9'h081, -1, 2'b11, lv, nb);
        send(0, lv, nb, 10);
        flush("f81", 2 * 87);

        // Reset during data bit 4, then back-to-back 0xF0, 0x0F
        build(0, 9'h0C3, -1, 2'b11, lv, nb);
        for (int i = 0; i < 5; i++) begin
            ser[0] = lv[i];
            repeat (87) @(posedge clk);
            #1;
        end
        ser[0] = lv[5];
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        ser[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        flush("midrst_none", 2 * 87);
        build(0, 9'h0F0, -1, 2'b11, lv, nb);
        send(0, lv, nb, 0);
        build(0, 9'h00F, -1, 2'b11, lv, nb);
        send(0, lv, nb, 10);
        flush("b2b", 2 * 87);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity and stop-bit count, an input synchroniser, 3-sample majority voting, and parity/framing/break error reporting. It sits between the board RX pin and the byte-level consumer (command parser or RX FIFO), which samples `o_RX_Byte` and the error flags on the `o_RX_DV` strobe.

## Interface
- `CLKS_PER_BIT`, default 87: clocks per bit period; legal range ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, 5..9, LSB first.
- `PARITY_MODE`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `i_Clock`, in, 1: single clock for all logic.
- `i_Reset`, in, 1: asynchronous, active-high reset.
- `i_RX_Serial`, in, 1: asynchronous serial line, idle high.
- `o_RX_DV`, out, 1: one-cycle strobe; frame complete.
- `o_RX_Byte`, out, DATA_BITS: received data; held until the next strobe.
- `o_Parity_Err`, out, 1: parity mismatch on the last frame; 0 when `PARITY_MODE` = 0.
- `o_Frame_Err`, out, 1: at least one stop bit sampled 0.
- `o_Break`, out, 1: all data, parity and stop samples were 0.

## Operation
- Synchroniser: 2 flops on `i_RX_Serial`. They reset to 1. All logic uses the synchronised line `rx_s`.
- Constants:
  - M = (CLKS_PER_BIT-1)/2 (integer division).
  - N = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
  - Bit counter width is $clog2(CLKS_PER_BIT).
- Per-bit timing: the counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - `rx_s` is sampled at counts M-1, M and M+1.
  - The bit value is the majority of the 3 samples, decided when count = M+1.
- States:
  - IDLE: counter held at 0. If `rx_s` = 0 and the arm flag is set, go to START.
  - START: if the majority is 1 at the decision point, treat as a glitch and go to IDLE. Otherwise continue to the bit boundary, then go to DATA.
  - DATA: shift each decided bit into position `bit_idx`. After DATA_BITS bits, go to PARITY if enabled, else to STOP.
  - PARITY: decide one bit. Parity error = (XOR of data bits ^ parity bit) != (PARITY_MODE == 2).
  - STOP: decide each stop bit. On the decision of the last stop bit:
    - register the byte and all error flags;
    - pulse `o_RX_DV`;
    - go directly to IDLE, without waiting for the bit end, so back-to-back frames are accepted.
- Arm flag: set while `rx_s` = 1 in IDLE. Cleared on leaving STOP with `o_Frame_Err` = 1. This stops a held-low line (break, or a stop error) from retriggering a start until the line returns high.
- Break: `o_Break` = 1 requires all data bits, the parity bit and every stop sample = 0. It implies `o_Frame_Err` = 1.
- Asynchronous reset, at any time including mid-frame, gives:
  - state IDLE, counters 0, arm flag 1;
  - `o_RX_DV`, `o_Parity_Err`, `o_Frame_Err` and `o_Break` = 0;
  - `o_RX_Byte` = 0.

## Timing
- Let edge e0 be the first `i_Clock` edge that samples `i_RX_Serial` low. Then:
  - IDLE sees `rx_s` low at e0+2;
  - START is entered with count 0 after e0+2.
- Decision for bit b (b = 0 is the start bit) is registered at e0 + b·CLKS_PER_BIT + M + 4.
- `o_RX_DV` is high for exactly the one cycle following edge e0 + (N-1)·CLKS_PER_BIT + M + 4.
  - 8N1 at 87: M = 43, `o_RX_DV` is high after e0+830.
- `o_RX_Byte` and the error flags update on the same edge as `o_RX_DV` rises, and are stable until the next strobe.
- There is no back-pressure; the consumer must take data in the strobe cycle.
- The earliest next start detection is the cycle after `o_RX_DV`.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - the parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - `uart_pkg::majority3` (3-input majority vote), also used by the transmitter bench.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with async reset to 1, reusable on other async inputs.

## Test plan
- 8N1, 87 clocks per bit, send 0xA5 → one `o_RX_DV` pulse after e0+830, `o_RX_Byte` = 0xA5, all error flags 0.
- 8E1, send 0x3C with parity bit 1 (wrong) → `o_RX_Byte` = 0x3C, `o_Parity_Err` = 1, `o_Frame_Err` = 0. Next frame 0x3C with parity 0 → `o_Parity_Err` = 0.
- 7O2, send 0x55 with second stop bit 0 → `o_Frame_Err` = 1, `o_RX_Byte` = 0x55. No new start until the line returns high.
- Line low for 12 bit periods, then high → exactly one strobe with `o_Break` = 1, `o_Frame_Err` = 1, `o_RX_Byte` = 0. No second strobe.
- Line low for 30 cycles (< M), then high → no strobe, state back to IDLE. A following 0x81 frame is received correctly.
- Assert `i_Reset` during data bit 4 of a frame, release, then send 0xF0 and 0x0F back-to-back with 1 stop bit → all outputs 0 during reset, then exactly two strobes carrying 0xF0 and 0x0F with no errors.
